// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan operand selector.
// Mode encodings and the select-width helper used by the top and the selector.
// Pure declarations; no logic.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Index width for n items, never less than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Purely combinational N:1 channel selector.
// Zero latency; an out-of-range select drives all-zero data.
// No flow control; the output follows the inputs.
module mux_nto1
  import mux_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        dout
);

  // One-hot style match over all channels; no match leaves the zero default.
  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) dout = in_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 operand selector with manual select and auto scan with dwell.
// One clock from sampled in_bus to mux_out; valid/wrap/sel_err are single-cycle pulses.
// en=0 freezes data, channel, pointer and dwell; no other backpressure.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int DWELL  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [sel_width(NUM_IN)-1:0] sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_bus,
  output logic [WIDTH-1:0]          mux_out,
  output logic [sel_width(NUM_IN)-1:0] ch_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int SEL_W = sel_width(NUM_IN);
  localparam int DW_W  = sel_width(DWELL);
  localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(NUM_IN - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  logic [SEL_W-1:0] ptr;
  logic [DW_W-1:0]  dwell_cnt;
  logic [SEL_W-1:0] cur_sel;
  logic [WIDTH-1:0] mux_dat;
  logic             sel_ok;

  // Auto mode reads from the scan pointer, manual mode from the caller.
  always_comb begin
    cur_sel = (mode == MODE_AUTO) ? ptr : sel;
    sel_ok  = (int'(sel) < NUM_IN);
  end

  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_bus (in_bus),
    .sel    (cur_sel),
    .dout   (mux_dat)
  );

  // Output registers plus scan pointer/dwell state; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_out   <= '0;
      ch_out    <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
      ptr       <= '0;
      dwell_cnt <= '0;
    end else begin
      valid   <= 1'b0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
      if (en) begin
        if (mode == MODE_AUTO) begin
          mux_out <= mux_dat;
          ch_out  <= ptr;
          valid   <= 1'b1;
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            wrap      <= (ptr == PTR_LAST);
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end else if (sel_ok) begin
          // Keeping ptr/dwell aligned to sel makes a later switch to auto
          // start on this channel with a full dwell.
          mux_out   <= mux_dat;
          ch_out    <= sel;
          valid     <= 1'b1;
          ptr       <= sel;
          dwell_cnt <= '0;
        end else begin
          sel_err <= 1'b1;
        end
      end
    end
  end

endmodule
